// File: rtl/uart_boot_ctrl_pkg.sv
// Shared definitions for the serial bootloader: sequencer states and
// word assembly geometry.
package uart_boot_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RESTART = 2'd2
  } bootState_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_boot_ctrl_timeout_cnt.sv
// Clearable up-counter with a terminal-count flag. The terminal value is an
// input so the same counter can time both the idle-line timeout and the CPU
// reset hold period.
module uart_boot_ctrl_timeout_cnt #(
  parameter int CW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] term_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority over counting; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register, returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/uart_boot_ctrl.sv
// Serial bootloader sequencer: packs little-endian UART bytes into 32-bit
// ROM words written from address 0, holds the CPU in reset while loading,
// and releases it after an idle-line timeout plus a short reset hold.
module uart_boot_ctrl
  import uart_boot_ctrl_pkg::*;
#(
  parameter int ROM_AW         = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RST_CYCLES     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_en_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rom_we_o,
  output logic [ROM_AW-1:0] rom_waddr_o,
  output logic [31:0]       rom_wdata_o,
  output logic              cpu_hold_o,
  output logic [ROM_AW:0]   word_cnt_o,
  output logic              boot_done_o,
  output logic              boot_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]         TO_TERM   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]         RST_TERM  = CW'(RST_CYCLES - 1);
  localparam logic [ROM_AW:0]       DEPTH_CNT = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX  = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  bootState_e            state_q;
  logic [BYTE_IDX_W-1:0] byteIdx_q;
  logic [23:0]           asmWord_q;
  logic                  romWe_q;
  logic [ROM_AW-1:0]     romWaddr_q;
  logic [31:0]           romWdata_q;
  logic                  cpuHold_q;
  logic [ROM_AW:0]       wordCnt_q;
  logic                  bootDone_q;
  logic                  bootErr_q;

  logic          cntClr;
  logic          cntEn;
  logic          cntTc;
  logic [CW-1:0] cntTerm;

  // Counter control: a received byte restarts the idle timeout, reaching
  // terminal count restarts it for the next phase, and it sits at zero in IDLE.
  always_comb begin
    cntClr  = 1'b1;
    cntEn   = 1'b0;
    cntTerm = TO_TERM;
    case (state_q)
      LOAD: begin
        cntClr = rx_valid_i || cntTc;
        cntEn  = !cntClr;
      end
      RESTART: begin
        cntTerm = RST_TERM;
        cntClr  = cntTc;
        cntEn   = !cntTc;
      end
      default: ;
    endcase
  end

  uart_boot_ctrl_timeout_cnt #(
    .CW(CW)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cntClr),
    .en_i   (cntEn),
    .term_i (cntTerm),
    .tc_o   (cntTc)
  );

  // Sequencer with registered outputs: assembles bytes, issues one write per
  // complete word while room remains, and tracks the sticky outcome flags.
  // A byte on the timeout terminal cycle takes priority over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byteIdx_q  <= '0;
      asmWord_q  <= '0;
      romWe_q    <= 1'b0;
      romWaddr_q <= '0;
      romWdata_q <= '0;
      cpuHold_q  <= 1'b0;
      wordCnt_q  <= '0;
      bootDone_q <= 1'b0;
      bootErr_q  <= 1'b0;
    end else begin
      romWe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_valid_i && boot_en_i) begin
            state_q    <= LOAD;
            cpuHold_q  <= 1'b1;
            wordCnt_q  <= '0;
            bootDone_q <= 1'b0;
            bootErr_q  <= 1'b0;
            asmWord_q  <= {16'h0000, rx_data_i};
            byteIdx_q  <= BYTE_IDX_W'(1);
          end
        end
        LOAD: begin
          if (rx_valid_i) begin
            if (wordCnt_q == DEPTH_CNT) begin
              bootErr_q <= 1'b1;
            end else if (byteIdx_q == LAST_IDX) begin
              romWe_q    <= 1'b1;
              romWaddr_q <= wordCnt_q[ROM_AW-1:0];
              romWdata_q <= {rx_data_i, asmWord_q};
              wordCnt_q  <= wordCnt_q + 1'b1;
              byteIdx_q  <= '0;
            end else begin
              case (byteIdx_q)
                BYTE_IDX_W'(0): asmWord_q[7:0]   <= rx_data_i;
                BYTE_IDX_W'(1): asmWord_q[15:8]  <= rx_data_i;
                default:        asmWord_q[23:16] <= rx_data_i;
              endcase
              byteIdx_q <= byteIdx_q + 1'b1;
            end
          end else if (cntTc) begin
            state_q   <= RESTART;
            byteIdx_q <= '0;
            asmWord_q <= '0;
            if (byteIdx_q != '0) begin
              bootErr_q <= 1'b1;
            end
          end
        end
        RESTART: begin
          if (cntTc) begin
            state_q    <= IDLE;
            cpuHold_q  <= 1'b0;
            bootDone_q <= !bootErr_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_we_o    = romWe_q;
  assign rom_waddr_o = romWaddr_q;
  assign rom_wdata_o = romWdata_q;
  assign cpu_hold_o  = cpuHold_q;
  assign word_cnt_o  = wordCnt_q;
  assign boot_done_o = bootDone_q;
  assign boot_err_o  = bootErr_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl using a small ROM, short timeout
// and short reset hold. Expected writes and flags come from a byte-list model.
module tb_uart_boot_ctrl;

  localparam int TB_AW      = 2;
  localparam int TB_DEPTH   = 4;
  localparam int TB_TIMEOUT = 64;
  localparam int TB_RST     = 4;

  logic              clk;
  logic              rst;
  logic              boot_en;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rom_we;
  logic [TB_AW-1:0]  rom_waddr;
  logic [31:0]       rom_wdata;
  logic              cpu_hold;
  logic [TB_AW:0]    word_cnt;
  logic              boot_done;
  logic              boot_err;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  dlBytes[$];
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];

  uart_boot_ctrl #(
    .ROM_AW         (TB_AW),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .RST_CYCLES     (TB_RST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_en_i   (boot_en),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rom_we_o    (rom_we),
    .rom_waddr_o (rom_waddr),
    .rom_wdata_o (rom_wdata),
    .cpu_hold_o  (cpu_hold),
    .word_cnt_o  (word_cnt),
    .boot_done_o (boot_done),
    .boot_err_o  (boot_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every ROM write seen on the port for later comparison with the model.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wrAddrQ.push_back(32'(rom_waddr));
      wrDataQ.push_back(rom_wdata);
    end
  end

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge; returns on the next falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Send dlBytes as one download and check it against the model: a write one
  // cycle after each 4th byte while the ROM has room, release of the CPU
  // TIMEOUT+RST cycles after the last byte, and the final counters/flags.
  // tcGapAfter selects a byte after which the next byte lands on terminal count.
  task automatic runDownload(input string tag, input bit flipEn, input int tcGapAfter);
    int n;
    int cyc;
    int expWrites;
    int w;
    logic [31:0] expWord;
    n = dlBytes.size();
    wrAddrQ.delete();
    wrDataQ.delete();
    boot_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      applyStimulus(dlBytes[i]);
      if (i == 0) begin
        checkOutput({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
        if (flipEn) boot_en = 1'b0;
      end
      if ((i % 4) == 3) begin
        w = i / 4;
        if (w < TB_DEPTH) begin
          expWord = {dlBytes[i], dlBytes[i-1], dlBytes[i-2], dlBytes[i-3]};
          checkOutput({tag, "_we"}, 32'(rom_we), 32'd1);
          checkOutput({tag, "_waddr"}, 32'(rom_waddr), 32'(w));
          checkOutput({tag, "_wdata"}, rom_wdata, expWord);
          checkOutput({tag, "_wcnt_run"}, 32'(word_cnt), 32'(w + 1));
        end else begin
          checkOutput({tag, "_ovf_no_we"}, 32'(rom_we), 32'd0);
          checkOutput({tag, "_ovf_wcnt"}, 32'(word_cnt), 32'(TB_DEPTH));
        end
      end
      if (i < n - 1) begin
        if (i == tcGapAfter) begin
          repeat (TB_TIMEOUT - 1) @(negedge clk);
        end else begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    end
    cyc = 0;
    while (cpu_hold === 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_release_lat"}, 32'(cyc), 32'(TB_TIMEOUT + TB_RST));
    expWrites = (n / 4 > TB_DEPTH) ? TB_DEPTH : n / 4;
    checkOutput({tag, "_nwrites"}, 32'(wrAddrQ.size()), 32'(expWrites));
    for (int k = 0; k < expWrites && k < wrAddrQ.size(); k++) begin
      expWord = {dlBytes[4*k+3], dlBytes[4*k+2], dlBytes[4*k+1], dlBytes[4*k]};
      checkOutput({tag, "_log_addr"}, wrAddrQ[k], 32'(k));
      checkOutput({tag, "_log_data"}, wrDataQ[k], expWord);
    end
    checkOutput({tag, "_word_cnt"}, 32'(word_cnt), 32'(expWrites));
    checkOutput({tag, "_boot_err"}, 32'(boot_err), 32'((n > 4 * TB_DEPTH) || (n % 4 != 0)));
    checkOutput({tag, "_boot_done"}, 32'(boot_done), 32'(!((n > 4 * TB_DEPTH) || (n % 4 != 0))));
    checkOutput({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
    boot_en = 1'b1;
  endtask

  // Fill dlBytes with n random bytes.
  task automatic randomBytes(input int n);
    dlBytes.delete();
    for (int i = 0; i < n; i++) dlBytes.push_back(8'($urandom));
  endtask

  // Directed sequence of scenarios followed by a few randomized downloads.
  initial begin
    rst      = 1'b1;
    boot_en  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_rom_we", 32'(rom_we), 32'd0);
    checkOutput("rst_waddr", 32'(rom_waddr), 32'd0);
    checkOutput("rst_wdata", rom_wdata, 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("rst_boot_done", 32'(boot_done), 32'd0);
    checkOutput("rst_boot_err", 32'(boot_err), 32'd0);

    wrAddrQ.delete();
    applyStimulus(8'hAA);
    repeat (3) @(negedge clk);
    checkOutput("gated_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("gated_word_cnt", 32'(word_cnt), 32'd0);
    checkOutput("gated_nwrites", 32'(wrAddrQ.size()), 32'd0);

    dlBytes = '{8'h93, 8'h00, 8'h10, 8'h00};
    runDownload("first_word", 1'b0, -1);
    checkOutput("first_word_const", (wrDataQ.size() > 0) ? wrDataQ[0] : 32'hDEADBEEF, 32'h00100093);

    randomBytes(8);
    runDownload("two_words", 1'b0, -1);

    randomBytes(6);
    runDownload("partial", 1'b0, -1);

    randomBytes(20);
    runDownload("overflow", 1'b1, -1);

    randomBytes(8);
    runDownload("tc_byte", 1'b0, 3);

    for (int r = 0; r < 4; r++) begin
      randomBytes($urandom_range(1, 22));
      runDownload("random", 1'($urandom_range(0, 1)), -1);
    end

    boot_en = 1'b1;
    randomBytes(6);
    for (int i = 0; i < 6; i++) applyStimulus(dlBytes[i]);
    checkOutput("pre_rst_word_cnt", 32'(word_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_hold", 32'(cpu_hold), 32'd0);
    checkOutput("async_rst_wcnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    randomBytes(4);
    runDownload("after_rst", 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
